// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad password checker.
package lock_pkg;

    typedef enum logic {
        ENTRY   = 1'b0,
        LOCKOUT = 1'b1
    } state_e;

    localparam int unsigned DEF_DIGIT_W = 4;
    localparam int unsigned MAX_DIGIT_W = 32;
    localparam int unsigned MAX_PWD_W   = 1024;

    // Digit idx of a packed password (digit 0 in the low bits), zero-extended to MAX_DIGIT_W.
    function automatic logic [MAX_DIGIT_W-1:0] digit_at(
        input logic [MAX_PWD_W-1:0] pwd,
        input int unsigned          idx,
        input int unsigned          dw = DEF_DIGIT_W
    );
        logic [MAX_PWD_W-1:0]   shifted;
        logic [MAX_DIGIT_W-1:0] mask;
        shifted = pwd >> (idx * dw);
        mask    = ~({MAX_DIGIT_W{1'b1}} << dw);
        return MAX_DIGIT_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter that times the lockout window.
module lockout_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_c
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    // Asserted in the cycle whose closing edge brings the count to zero.
    assign done_c = en_i && (count_q == WIDTH'(1));

endmodule

// File: rtl/pwd_entry_judge.sv
// Digit-by-digit password checker with unlock/fail pulses and timed lockout.
module pwd_entry_judge
    import lock_pkg::*;
#(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned DIGIT_W     = DEF_DIGIT_W,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCK_CYCLES = 1000
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               key_valid,
    input  logic [DIGIT_W-1:0]                 key_digit,
    input  logic                               key_clear,
    input  logic                               key_enter,
    input  logic [DIGITS*DIGIT_W-1:0]          ref_pwd,
    output logic                               unlock,
    output logic                               fail,
    output logic                               locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic [$clog2(DIGITS+1)-1:0]        digit_cnt
);

    localparam int unsigned CW    = $clog2(DIGITS + 1);
    localparam int unsigned TW    = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMR_W = $clog2(LOCK_CYCLES + 1);

    state_e          state_q;
    logic [CW-1:0]   digit_cnt_q;
    logic [TW-1:0]   tries_q;
    logic            mismatch_q;
    logic            unlock_q;
    logic            fail_q;
    logic            locked_q;

    logic [DIGIT_W-1:0] ref_digit_c;
    logic               cnt_full_c;
    logic               match_c;
    logic               last_try_c;
    logic               tmr_load_c;
    logic               tmr_done_c;

    assign ref_digit_c = DIGIT_W'(digit_at(MAX_PWD_W'(ref_pwd), 32'(digit_cnt_q), DIGIT_W));
    assign cnt_full_c  = (digit_cnt_q == CW'(DIGITS));
    assign match_c     = cnt_full_c && !mismatch_q;
    assign last_try_c  = (tries_q <= TW'(1));

    // Timer is loaded on the same edge that raises locked.
    assign tmr_load_c = (state_q == ENTRY) && !key_clear && key_enter && !match_c && last_try_c;

    lockout_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_c),
        .load_val_i (TMR_W'(LOCK_CYCLES)),
        .en_i       (state_q == LOCKOUT),
        .done_c     (tmr_done_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ENTRY;
            digit_cnt_q <= '0;
            tries_q     <= TW'(MAX_TRIES);
            mismatch_q  <= 1'b0;
            unlock_q    <= 1'b0;
            fail_q      <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            unlock_q <= 1'b0;
            fail_q   <= 1'b0;
            case (state_q)
                ENTRY: begin
                    if (key_clear) begin
                        digit_cnt_q <= '0;
                        mismatch_q  <= 1'b0;
                    end else if (key_enter) begin
                        digit_cnt_q <= '0;
                        mismatch_q  <= 1'b0;
                        if (match_c) begin
                            unlock_q <= 1'b1;
                            tries_q  <= TW'(MAX_TRIES);
                        end else begin
                            fail_q <= 1'b1;
                            if (last_try_c) begin
                                tries_q  <= '0;
                                locked_q <= 1'b1;
                                state_q  <= LOCKOUT;
                            end else begin
                                tries_q <= tries_q - TW'(1);
                            end
                        end
                    end else if (key_valid) begin
                        // Digits beyond the password length poison the attempt.
                        if (cnt_full_c) begin
                            mismatch_q <= 1'b1;
                        end else begin
                            if (key_digit != ref_digit_c) begin
                                mismatch_q <= 1'b1;
                            end
                            digit_cnt_q <= digit_cnt_q + CW'(1);
                        end
                    end
                end
                LOCKOUT: begin
                    if (tmr_done_c) begin
                        state_q     <= ENTRY;
                        locked_q    <= 1'b0;
                        tries_q     <= TW'(MAX_TRIES);
                        digit_cnt_q <= '0;
                        mismatch_q  <= 1'b0;
                    end
                end
                default: state_q <= ENTRY;
            endcase
        end
    end

    assign unlock     = unlock_q;
    assign fail       = fail_q;
    assign locked     = locked_q;
    assign tries_left = tries_q;
    assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_pwd_entry_judge.sv
// Self-checking bench for pwd_entry_judge against a queue-based attempt model.
module tb_pwd_entry_judge;

    localparam int DIGITS      = 6;
    localparam int DIGIT_W     = 4;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 10;

    typedef struct packed {
        logic       v;
        logic [3:0] d;
        logic       c;
        logic       e;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clear;
    logic        key_enter;
    logic [23:0] ref_pwd;
    logic        unlock;
    logic        fail;
    logic        locked;
    logic [1:0]  tries_left;
    logic [2:0]  digit_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: the attempt as a list of (typed, expected) digit pairs.
    logic [3:0] m_keys[$];
    logic [3:0] m_refs[$];
    bit         m_over;
    int         m_tries;
    int         m_lock_left;
    bit         m_unlock;
    bit         m_fail;

    pwd_entry_judge #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .key_enter  (key_enter),
        .ref_pwd    (ref_pwd),
        .unlock     (unlock),
        .fail       (fail),
        .locked     (locked),
        .tries_left (tries_left),
        .digit_cnt  (digit_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t k(input int d);
        return '{v: 1'b1, d: 4'(d), c: 1'b0, e: 1'b0};
    endfunction
    function automatic stim_t ent();
        return '{v: 1'b0, d: 4'd0, c: 1'b0, e: 1'b1};
    endfunction
    function automatic stim_t idle();
        return '{v: 1'b0, d: 4'd0, c: 1'b0, e: 1'b0};
    endfunction

    function automatic logic [3:0] ref_digit(input int i);
        logic [23:0] p;
        p = ref_pwd;
        return p[i*4 +: 4];
    endfunction

    function automatic logic [7:0] obs();
        return {unlock, fail, locked, tries_left, digit_cnt};
    endfunction

    function automatic logic [7:0] mexp();
        return {m_unlock, m_fail, (m_lock_left > 0), 2'(m_tries), 3'(m_keys.size())};
    endfunction

    task automatic model_reset();
        m_keys.delete();
        m_refs.delete();
        m_over      = 1'b0;
        m_tries     = MAX_TRIES;
        m_lock_left = 0;
        m_unlock    = 1'b0;
        m_fail      = 1'b0;
    endtask

    task automatic model_clear();
        m_keys.delete();
        m_refs.delete();
        m_over = 1'b0;
    endtask

    task automatic model_step(input stim_t s);
        bit ok;
        m_unlock = 1'b0;
        m_fail   = 1'b0;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_tries = MAX_TRIES;
                model_clear();
            end
        end else if (s.c) begin
            model_clear();
        end else if (s.e) begin
            ok = (m_keys.size() == DIGITS) && !m_over;
            foreach (m_keys[i]) if (m_keys[i] != m_refs[i]) ok = 1'b0;
            model_clear();
            if (ok) begin
                m_unlock = 1'b1;
                m_tries  = MAX_TRIES;
            end else begin
                m_fail = 1'b1;
                m_tries--;
                if (m_tries == 0) m_lock_left = LOCK_CYCLES;
            end
        end else if (s.v) begin
            if (m_keys.size() < DIGITS) begin
                m_refs.push_back(ref_digit(m_keys.size()));
                m_keys.push_back(s.d);
            end else begin
                m_over = 1'b1;
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, settle 1ns.
    task automatic tick(input stim_t s);
        @(negedge clk);
        key_valid = s.v;
        key_digit = s.d;
        key_clear = s.c;
        key_enter = s.e;
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_valid = 1'b0; key_digit = 4'd0; key_clear = 1'b0; key_enter = 1'b0;
        ref_pwd = 24'h654321;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 8'b0_0_0_11_000) begin
            errors++;
            $display("FAIL reset_values: got %b want %b", obs(), 8'b0_0_0_11_000);
        end
        rst_n = 1'b1;
        tick(idle());
        checks++;
        if (obs() !== mexp()) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", obs(), mexp());
        end
    endtask

    task automatic test_correct_entry();
        stim_t seq[$];
        int n_unlock = 0, n_fail = 0;
        seq = {k(1), k(2), k(3), k(4), k(5), k(6), ent(), idle(), idle()};
        foreach (seq[i]) begin
            tick(seq[i]);
            n_unlock += int'(unlock);
            n_fail   += int'(fail);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL correct_entry step %0d: got %b want %b", i, obs(), mexp());
            end
        end
        checks++;
        if (n_unlock != 1 || n_fail != 0) begin
            errors++;
            $display("FAIL correct_entry_pulses: unlock=%0d fail=%0d want 1/0", n_unlock, n_fail);
        end
    endtask

    task automatic test_wrong_digit();
        stim_t seq[$];
        seq = {k(1), k(2), k(9), k(4), k(5), k(6), ent(), idle(),
               k(1), k(2), k(3), k(4), k(5), k(6), ent(), idle()};
        foreach (seq[i]) begin
            tick(seq[i]);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL wrong_digit step %0d: got %b want %b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_length_errors();
        stim_t seq[$];
        seq = {k(1), k(2), k(3), k(4), k(5), ent(), idle(),
               k(1), k(2), k(3), k(4), k(5), k(6), k(7)};
        foreach (seq[i]) begin
            tick(seq[i]);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL length step %0d: got %b want %b", i, obs(), mexp());
            end
        end
        checks++;
        if (digit_cnt !== 3'd6) begin
            errors++;
            $display("FAIL overlength_cnt: got %0d want 6", digit_cnt);
        end
        seq = {ent(), idle(), k(1), k(2), k(3), k(4), k(5), k(6), ent(), idle()};
        foreach (seq[i]) begin
            tick(seq[i]);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL overlength step %0d: got %b want %b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_lockout();
        stim_t seq[$];
        int n_locked = 0, n_pulse = 0;
        for (int t = 0; t < 3; t++)
            seq = {seq, k(6), k(5), k(4), k(3), k(2), k(1), ent()};
        for (int t = 0; t < 6; t++) seq = {seq, k(1), ent()};
        seq = {seq, idle(), idle(), idle(), k(1), k(2), k(3), k(4), k(5), k(6), ent(), idle()};
        foreach (seq[i]) begin
            tick(seq[i]);
            n_locked += int'(locked);
            if (locked) n_pulse += int'(unlock) + int'(fail);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL lockout step %0d: got %b want %b", i, obs(), mexp());
            end
        end
        checks++;
        if (n_locked != LOCK_CYCLES) begin
            errors++;
            $display("FAIL lockout_duration: got %0d cycles want %0d", n_locked, LOCK_CYCLES);
        end
        checks++;
        if (n_pulse != 1) begin
            errors++;
            $display("FAIL lockout_pulses: got %0d pulses while locked want 1 (the final fail)", n_pulse);
        end
    endtask

    task automatic test_priority();
        stim_t seq[$];
        stim_t ce, ve;
        ce = '{v: 1'b0, d: 4'd0, c: 1'b1, e: 1'b1};
        ve = '{v: 1'b1, d: 4'd7, c: 1'b0, e: 1'b1};
        seq = {k(1), k(2), k(3), k(4), k(5), k(6), ce, idle(),
               k(1), k(2), k(3), k(4), k(5), k(6), ve, idle()};
        foreach (seq[i]) begin
            tick(seq[i]);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL priority step %0d: got %b want %b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t seq[$];
        for (int t = 0; t < 3; t++)
            seq = {seq, k(9), ent()};
        seq = {seq, idle(), idle(), idle()};
        foreach (seq[i]) begin
            tick(seq[i]);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL async_pre step %0d: got %b want %b", i, obs(), mexp());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs() !== 8'b0_0_0_11_000) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b want %b", obs(), 8'b0_0_0_11_000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(idle());
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL async_post step %0d: got %b want %b", i, obs(), mexp());
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            s = idle();
            if (r < 3) s.c = 1'b1;
            else if (r < 15) s.e = 1'b1;
            else if (r < 85) begin
                s.v = 1'b1;
                s.d = ($urandom_range(0, 3) != 0) ? ref_digit(m_keys.size() % DIGITS) : 4'($urandom);
            end
            if (r < 20) begin
                s.v = s.v | 1'($urandom);
                s.c = s.c | ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 49) == 0) ref_pwd = 24'($urandom);
            tick(s);
            checks++;
            if (obs() !== mexp()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", i, obs(), mexp());
            end
        end
        ref_pwd = 24'h654321;
    endtask

    initial begin
        test_reset();
        test_correct_entry();
        test_wrong_digit();
        test_length_errors();
        test_lockout();
        test_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
